// File: rtl/edge_trigger_holdoff_mc.sv
// rtl/edge_trigger_holdoff_mc.sv - multi-channel qualified edge trigger with retrigger holdoff
//
// Purpose: per channel, emit a one-cycle pulse once an edge of the selected
// polarity has held its new level for qual_i cycles, then ignore the input for
// hold_i+1 cycles.
// Optional feature macro: EDGE_CNT_EN (per-channel 32-bit saturating event counters).
//
// Ports:
//   clk_i    system clock
//   rstn_i   synchronous active-low reset
//   din_i    [CH] raw inputs, already in clk_i domain
//   en_i     [CH] per-channel enable
//   mode_i   [2]  00 rising, 01 falling, 10 both, 11 off
//   qual_i   [QW] qualification length (0 behaves as 1)
//   hold_i   [HW] holdoff length, sampled on entry to holdoff
//   pulse_o  [CH] one-cycle trigger pulse
//   busy_o   [CH] channel qualifying or holding off
//   clr_i         clear event counters          (EDGE_CNT_EN only)
//   cnt_o    [CH*32] event counters, ch k at [32k +: 32] (EDGE_CNT_EN only)
module edge_trigger_holdoff_mc #(
  parameter int CH = 4,
  parameter int QW = 8,
  parameter int HW = 16
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic [CH-1:0]     din_i,
  input  logic [CH-1:0]     en_i,
  input  logic [1:0]        mode_i,
  input  logic [QW-1:0]     qual_i,
  input  logic [HW-1:0]     hold_i,
  output logic [CH-1:0]     pulse_o,
  output logic [CH-1:0]     busy_o
`ifdef EDGE_CNT_EN
  ,
  input  logic              clr_i,
  output logic [CH*32-1:0]  cnt_o
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_QUAL = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          st_q   [CH];
  logic [QW-1:0]   qcnt_q [CH];
  logic [HW-1:0]   hcnt_q [CH];
  logic [CH-1:0]   d_q;
  logic [CH-1:0]   lvl_q;

  logic [QW-1:0]   qe;
  logic [CH-1:0]   diff;
  logic [CH-1:0]   pol;
  logic [CH-1:0]   fire;
  logic [CH-1:0]   active;

  // fire marks the edge on which a channel commits to a pulse; it feeds both
  // the pulse register and the optional counters so they stay in lockstep.
  always_comb begin
    logic [QW:0] qinc;
    qinc   = '0;
    qe     = (qual_i == '0) ? QW'(1) : qual_i;
    diff   = '0;
    pol    = '0;
    fire   = '0;
    active = '0;
    for (int k = 0; k < CH; k++) begin
      diff[k]   = d_q[k] ^ lvl_q[k];
      active[k] = en_i[k] && (mode_i != 2'b11);
      case (mode_i)
        2'b00:   pol[k] = d_q[k] & ~lvl_q[k];
        2'b01:   pol[k] = ~d_q[k] & lvl_q[k];
        2'b10:   pol[k] = diff[k];
        default: pol[k] = 1'b0;
      endcase
      qinc = {1'b0, qcnt_q[k]} + (QW+1)'(1);
      // qual_i is read live: lowering it below the running count fires at once.
      fire[k] = active[k] && diff[k] &&
                (((st_q[k] == S_IDLE) && pol[k] && (qe == QW'(1))) ||
                 ((st_q[k] == S_QUAL) && (qinc >= {1'b0, qe})));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      d_q     <= '0;
      lvl_q   <= '0;
      pulse_o <= '0;
      busy_o  <= '0;
      for (int k = 0; k < CH; k++) begin
        st_q[k]   <= S_IDLE;
        qcnt_q[k] <= '0;
        hcnt_q[k] <= '0;
      end
    end else begin
      d_q     <= din_i;
      pulse_o <= fire;
      for (int k = 0; k < CH; k++) begin
        if (!active[k]) begin
          // Track the input while disabled so re-enable never sees a stale edge.
          st_q[k]   <= S_IDLE;
          busy_o[k] <= 1'b0;
          lvl_q[k]  <= d_q[k];
        end else begin
          case (st_q[k])
            S_IDLE: begin
              if (diff[k]) begin
                if (fire[k]) begin
                  lvl_q[k]  <= d_q[k];
                  hcnt_q[k] <= hold_i;
                  st_q[k]   <= S_HOLD;
                  busy_o[k] <= 1'b1;
                end else if (pol[k]) begin
                  qcnt_q[k] <= QW'(1);
                  st_q[k]   <= S_QUAL;
                  busy_o[k] <= 1'b1;
                end else begin
                  lvl_q[k] <= d_q[k];
                end
              end
            end
            S_QUAL: begin
              if (!diff[k]) begin
                // Input fell back before qualifying: a glitch, level unchanged.
                st_q[k]   <= S_IDLE;
                busy_o[k] <= 1'b0;
              end else if (fire[k]) begin
                lvl_q[k]  <= d_q[k];
                hcnt_q[k] <= hold_i;
                st_q[k]   <= S_HOLD;
                busy_o[k] <= 1'b1;
              end else begin
                qcnt_q[k] <= qcnt_q[k] + QW'(1);
              end
            end
            S_HOLD: begin
              lvl_q[k] <= d_q[k];
              if (hcnt_q[k] == '0) begin
                st_q[k]   <= S_IDLE;
                busy_o[k] <= 1'b0;
              end else begin
                hcnt_q[k] <= hcnt_q[k] - HW'(1);
              end
            end
            default: begin
              st_q[k]   <= S_IDLE;
              busy_o[k] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

`ifdef EDGE_CNT_EN
  logic [31:0] cnt_q [CH];

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      for (int k = 0; k < CH; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        if (clr_i)
          cnt_q[k] <= fire[k] ? 32'd1 : 32'd0;
        else if (fire[k] && (cnt_q[k] != 32'hFFFF_FFFF))
          cnt_q[k] <= cnt_q[k] + 32'd1;
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_cnt
    assign cnt_o[32*g +: 32] = cnt_q[g];
  end
`endif

endmodule
